mem_access_ctrl: RTL and testbench

//  Initiator-side controller for the 8-word x 8-bit memory cell array.

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/word_sel_decoder.sv | 29 ++
 rtl/mem_access_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory access controller slice:
//   - state_t    : controller FSM states
//   - RW_WRITE / RW_READ : array direction encodings
//   - ADDR_W_DEF / DATA_W_DEF : default array geometry (8 words x 8 bits)
//   - in_access() : true in the states that drive the array bus
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Explicit encodings keep the state register stable across tools.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    // The array bus (select, direction, data) is driven only while an
    // access is in its setup, strobe or hold phase.
    function automatic logic in_access(input state_t s);
        logic r;
        case (s)
            SETUP:   r = 1'b1;
            STROBE:  r = 1'b1;
            HOLD:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/word_sel_decoder.sv
// ---------------------------------------------------------------------------
// word_sel_decoder
// Combinational binary-to-one-hot word select decoder.
// Ports:
//   en   in   1          decode enable; output is all-zero when low
//   addr in   ADDR_W     word index
//   sel  out  1<<ADDR_W  one-hot select (at most one bit set)
// ---------------------------------------------------------------------------
module word_sel_decoder #(
    parameter int ADDR_W = 3
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        addr,
    output logic [(1<<ADDR_W)-1:0]   sel
);

    localparam int WORDS = 1 << ADDR_W;

    // One-hot decode of the word index, gated by enable.
    always_comb begin
        sel = {WORDS{1'b0}};
        if (en) begin
            sel[addr] = 1'b1;
        end else begin
            sel = {WORDS{1'b0}};
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Initiator-side controller for the 8-word x 8-bit memory cell array.
// Takes one read/write request at a time on a valid/ready port, runs the
// array through a setup / strobe / hold access, and returns the read data
// (or the written data, for writes) on a valid/ready response port.
// This block is the only driver of the array's control inputs.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   req_valid/req_ready        request handshake
//   req_rw/req_addr/req_wdata  request: 1 = write, word index, write data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata                  read data, or written data on writes
//   mem_valid                  array access strobe
//   mem_sel                    one-hot word select
//   mem_rw                     array direction (1 = write)
//   mem_wdata/mem_rdata        array data out / in
//
// Timing: the array-side and response outputs are a registered image of
// the FSM state, so they trail the state register by one cycle. req_ready
// is registered from the next state instead, so it drops on the very edge
// that accepts a request and a second request can never slip in.
// With handshake edge E0, rsp_valid is first high after E0+3+STROBE_CYCLES.
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     mem_valid,
    output logic [(1<<ADDR_W)-1:0]   mem_sel,
    output logic                     mem_rw,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int WORDS = 1 << ADDR_W;

    // Out-of-range strobe lengths are clamped into 1..15 so the counter
    // can never be loaded with zero or overflow its width.
    localparam int STROBE_N = (STROBE_CYCLES < 1)  ? 1  :
                              (STROBE_CYCLES > 15) ? 15 : STROBE_CYCLES;
    localparam int CNT_W    = $clog2(STROBE_N + 1);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STROBE_N);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    // FSM and strobe counter
    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;

    // Latched request
    logic               rw_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;

    // Registered outputs
    logic               req_ready_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               mem_valid_r;
    logic [WORDS-1:0]   mem_sel_r;
    logic               mem_rw_r;
    logic [DATA_W-1:0]  mem_wdata_r;

    // Marks the output cycle that is the final strobe cycle of an access.
    logic               last_strobe_r;

    logic               req_fire_s;
    logic               rsp_fire_s;
    logic               access_s;
    logic               strobe_done_s;
    logic [WORDS-1:0]   dec_sel_s;

    assign req_fire_s    = req_valid & req_ready_r;
    assign rsp_fire_s    = rsp_valid_r & rsp_ready;
    assign access_s      = in_access(state_r);
    // "<=" rather than "==" so a corrupted zero count still leaves STROBE.
    assign strobe_done_s = (cnt_r <= CNT_ONE);

    word_sel_decoder #(
        .ADDR_W (ADDR_W)
    ) u_word_sel_decoder (
        .en   (access_s),
        .addr (addr_r),
        .sel  (dec_sel_s)
    );

    // Next-state and strobe counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_fire_s) begin
                    state_nx_s = SETUP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETUP: begin
                state_nx_s = STROBE;
                cnt_nx_s   = CNT_RELOAD;
            end
            STROBE: begin
                if (strobe_done_s) begin
                    state_nx_s = HOLD;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    state_nx_s = STROBE;
                    cnt_nx_s   = cnt_r - CNT_ONE;
                end
            end
            HOLD: begin
                state_nx_s = RESP;
            end
            RESP: begin
                if (rsp_fire_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Request capture on the accepting handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_r    <= RW_READ;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (req_fire_s) begin
            rw_r    <= req_rw;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end else begin
            rw_r    <= rw_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Request-side ready, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r <= 1'b1;
        end else begin
            req_ready_r <= (state_nx_s == IDLE);
        end
    end

    // Array-side outputs: a registered image of the current state. Select,
    // direction and data change only on edges where mem_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_r   <= 1'b0;
            mem_sel_r     <= {WORDS{1'b0}};
            mem_rw_r      <= RW_READ;
            mem_wdata_r   <= {DATA_W{1'b0}};
            last_strobe_r <= 1'b0;
        end else begin
            mem_valid_r   <= (state_r == STROBE);
            mem_sel_r     <= dec_sel_s;
            mem_rw_r      <= access_s ? rw_r : RW_READ;
            mem_wdata_r   <= access_s ? wdata_r : {DATA_W{1'b0}};
            last_strobe_r <= (state_r == STROBE) && strobe_done_s;
        end
    end

    // Response path: data is captured on the edge ending the last strobe
    // cycle; rsp_valid rises one cycle after RESP is entered and falls on
    // the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rsp_valid_r <= (state_r == RESP) && !rsp_fire_s;
            if (mem_valid_r && last_strobe_r) begin
                rsp_rdata_r <= (mem_rw_r == RW_WRITE) ? mem_wdata_r : mem_rdata;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign mem_valid = mem_valid_r;
    assign mem_sel   = mem_sel_r;
    assign mem_rw    = mem_rw_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. Instance dut uses STROBE_CYCLES = 1,
// instance dut4 uses STROBE_CYCLES = 4; each talks to its own 8x8 array
// model built in the bench.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic clk;
    logic rst;

    // STROBE_CYCLES = 1 instance signals
    logic       req_valid, req_ready, req_rw;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       mem_valid, mem_rw;
    logic [7:0] mem_sel, mem_wdata, mem_rdata;

    // STROBE_CYCLES = 4 instance signals
    logic       req_valid4, req_ready4, req_rw4;
    logic [2:0] req_addr4;
    logic [7:0] req_wdata4;
    logic       rsp_valid4, rsp_ready4;
    logic [7:0] rsp_rdata4;
    logic       mem_valid4, mem_rw4;
    logic [7:0] mem_sel4, mem_wdata4, mem_rdata4;

    logic [7:0] arr1 [8];
    logic [7:0] arr4 [8];

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.ADDR_W(3), .DATA_W(8), .STROBE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_rw(mem_rw),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.ADDR_W(3), .DATA_W(8), .STROBE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_rw(req_rw4),
        .req_addr(req_addr4), .req_wdata(req_wdata4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_rdata(rsp_rdata4),
        .mem_valid(mem_valid4), .mem_sel(mem_sel4), .mem_rw(mem_rw4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned oh_idx(input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            if (s[i]) return i;
        end
        return 0;
    endfunction

    // Array models: write on a strobed write edge, read combinationally.
    always @(posedge clk) begin
        if (mem_valid && mem_rw) arr1[oh_idx(mem_sel)] <= mem_wdata;
        if (mem_valid4 && mem_rw4) arr4[oh_idx(mem_sel4)] <= mem_wdata4;
    end
    assign mem_rdata  = mem_valid  ? arr1[oh_idx(mem_sel)]  : 8'h00;
    assign mem_rdata4 = mem_valid4 ? arr4[oh_idx(mem_sel4)] : 8'h00;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [2:0] a);
        return {a, 2'b01, a} ^ 8'h5A;
    endfunction

    // One complete access on dut with cycle-by-cycle phase checks.
    task automatic txn1(input logic rw, input logic [2:0] a,
                        input logic [7:0] wd, input logic [7:0] exp);
        logic [7:0] oh;
        oh = 8'h01 << a;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
        check("t1_ready_idle", req_ready, 1'b1);
        step();                                   // handshake edge E0
        req_valid = 1'b0;
        check("t1_ready_busy", req_ready, 1'b0);
        check("t1_sel_c1", mem_sel, 8'h00);
        step();                                   // setup phase
        check("t1_sel_setup", mem_sel, oh);
        check("t1_valid_setup", mem_valid, 1'b0);
        check("t1_rw_setup", mem_rw, rw);
        check("t1_wdata_setup", mem_wdata, wd);
        step();                                   // strobe phase
        check("t1_valid_strobe", mem_valid, 1'b1);
        check("t1_sel_strobe", mem_sel, oh);
        check("t1_rw_strobe", mem_rw, rw);
        step();                                   // hold phase
        check("t1_valid_hold", mem_valid, 1'b0);
        check("t1_sel_hold", mem_sel, oh);
        check("t1_rsp_early", rsp_valid, 1'b0);
        step();                                   // E0+4: response
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_rsp_rdata", rsp_rdata, exp);
        check("t1_sel_resp", mem_sel, 8'h00);
        check("t1_rw_resp", mem_rw, 1'b0);
        step();                                   // response handshake done
        check("t1_rsp_done", rsp_valid, 1'b0);
        check("t1_ready_back", req_ready, 1'b1);
    endtask

    // One access on dut4, with bounded wait and per-cycle select checks.
    task automatic txn4(input logic rw, input logic [2:0] a,
                        input logic [7:0] wd, input logic [7:0] exp);
        logic [7:0] oh;
        int vcnt, lat, badsel;
        logic done;
        oh = 8'h01 << a;
        req_valid4 = 1'b1; req_rw4 = rw; req_addr4 = a; req_wdata4 = wd;
        step();                                   // handshake edge E0
        req_valid4 = 1'b0;
        vcnt = 0; lat = 0; badsel = 0; done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (mem_valid4) vcnt++;
            if ($countones(mem_sel4) > 1 || (mem_sel4 != 8'h00 && mem_sel4 != oh)) badsel++;
            if (rsp_valid4) begin
                done = 1'b1;
            end else begin
                step();
                lat++;
            end
        end
        check("t5_rsp_seen", done, 1'b1);
        check("t5_latency", lat, 32'd7);
        check("t5_strobe_len", vcnt, 32'd4);
        check("t5_onehot", badsel, 32'd0);
        check("t5_rdata", rsp_rdata4, exp);
        step();
        check("t5_rsp_done", rsp_valid4, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 3'd0; req_wdata = 8'h00; rsp_ready = 1'b0;
        req_valid4 = 1'b0; req_rw4 = 1'b0; req_addr4 = 3'd0; req_wdata4 = 8'h00; rsp_ready4 = 1'b1;
        #12 rst = 1'b0;
        step();

        // Reset state
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_sel", mem_sel, 8'h00);
        check("rst_mem_rw", mem_rw, 1'b0);
        check("rst_mem_wdata", mem_wdata, 8'h00);

        // 1: write A5 to addr 3
        txn1(1'b1, 3'd3, 8'hA5, 8'hA5);

        // 2: write 3C to addr 7, read it back, then read addr 3
        txn1(1'b1, 3'd7, 8'h3C, 8'h3C);
        txn1(1'b0, 3'd7, 8'h00, 8'h3C);
        txn1(1'b0, 3'd3, 8'h00, 8'hA5);

        // 3: backpressure
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 3'd5; req_wdata = 8'h5A; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        check("t3_rsp_valid", rsp_valid, 1'b1);
        check("t3_rsp_rdata", rsp_rdata, 8'h5A);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 3'd1; req_wdata = 8'h11;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t3_bp_valid", rsp_valid, 1'b1);
            check("t3_bp_rdata", rsp_rdata, 8'h5A);
            check("t3_bp_ready", req_ready, 1'b0);
            check("t3_bp_memvalid", mem_valid, 1'b0);
        end
        rsp_ready = 1'b1;
        step();                                   // response handshake
        check("t3_rel_rsp", rsp_valid, 1'b0);
        check("t3_rel_ready", req_ready, 1'b1);
        step();                                   // new request accepted here
        req_valid = 1'b0;
        check("t3_acc_ready", req_ready, 1'b0);
        step();
        check("t3_new_sel", mem_sel, 8'h02);
        check("t3_new_wdata", mem_wdata, 8'h11);
        repeat (3) step();
        check("t3_new_rsp", rsp_valid, 1'b1);
        check("t3_new_rdata", rsp_rdata, 8'h11);
        step();
        check("t3_new_done", rsp_valid, 1'b0);

        // 4: reset during the strobe
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 3'd6; req_wdata = 8'h66; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("t4_in_strobe", mem_valid, 1'b1);
        check("t4_sel_strobe", mem_sel, 8'h40);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_valid", mem_valid, 1'b0);
        check("t4_rst_sel", mem_sel, 8'h00);
        check("t4_rst_rsp", rsp_valid, 1'b0);
        check("t4_rst_ready", req_ready, 1'b1);
        check("t4_rst_rw", mem_rw, 1'b0);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t4_no_rsp", rsp_valid, 1'b0);
            check("t4_no_strobe", mem_valid, 1'b0);
        end
        check("t4_idle_ready", req_ready, 1'b1);

        // 5: STROBE_CYCLES = 4, fill all words then read back
        for (int a = 0; a < 8; a++) begin
            txn4(1'b1, 3'(a), pat(3'(a)), pat(3'(a)));
        end
        for (int a = 0; a < 8; a++) begin
            txn4(1'b0, 3'(a), 8'h00, pat(3'(a)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
